// File: rtl/result_serializer.sv
// ============================================================================
// result_serializer
// Queues wide results in a FIFO and streams each word MSB-chunk-first with an
// all-ones marker per active beat; bus is all zeros when idle.
// Revision: 1.0
// ============================================================================
`default_nettype none

module result_serializer #(
  parameter int DATA_W  = 16,
  parameter int CHUNK_W = 8,
  parameter int MARK_W  = 2,
  parameter int DEPTH   = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic [DATA_W-1:0]         in_data,
  output logic                      in_ready,
  input  logic                      out_stall,
  output logic [CHUNK_W+MARK_W-1:0] out,
  output logic                      out_last,
  output logic                      busy
);

  localparam int c_NCHUNK = (DATA_W + CHUNK_W - 1) / CHUNK_W;
  localparam int c_EXT_W  = c_NCHUNK * CHUNK_W;
  localparam int c_PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_CNT_W  = $clog2(DEPTH + 1);
  localparam int c_K_W    = (c_NCHUNK > 1) ? $clog2(c_NCHUNK) : 1;

  localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(DEPTH - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(DEPTH);
  localparam logic [c_K_W-1:0]   c_K_LAST   = c_K_W'(c_NCHUNK - 1);
  localparam logic [MARK_W-1:0]  c_MARK     = '1;
  localparam logic               c_SINGLE   = (c_NCHUNK == 1);

  if (DATA_W < CHUNK_W || CHUNK_W < 1 || MARK_W < 1 || DEPTH < 1) begin : g_param_check
    $error("result_serializer: illegal parameters (need DATA_W>=CHUNK_W>=1, MARK_W>=1, DEPTH>=1)");
  end

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_EMIT = 1'b1
  } state_t;

  // ---------------- result FIFO ----------------
  logic [DATA_W-1:0]  r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic               w_push;
  logic               w_pop;
  logic [c_EXT_W-1:0] w_head_ext;

  assign in_ready   = (r_count < c_CNT_FULL);
  assign w_push     = in_valid && in_ready;
  assign w_head_ext = c_EXT_W'(r_mem[r_rd_ptr]);

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= in_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

  // ---------------- output FSM ----------------
  state_t                      r_state, w_state_nxt;
  logic [c_EXT_W-1:0]          r_word, w_word_nxt;
  logic [c_K_W-1:0]            r_k, w_k_nxt, w_k_inc;
  logic [CHUNK_W+MARK_W-1:0]   r_out, w_out_nxt;
  logic                        r_last, w_last_nxt;
  logic                        w_fifo_ne;

  assign w_fifo_ne = (r_count != '0);
  assign w_k_inc   = r_k + 1'b1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_word  <= '0;
      r_k     <= '0;
      r_out   <= '0;
      r_last  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_word  <= w_word_nxt;
      r_k     <= w_k_nxt;
      r_out   <= w_out_nxt;
      r_last  <= w_last_nxt;
    end
  end

  // r_word holds the not-yet-emitted chunks left-aligned, so the next chunk is
  // always the top slice.
  always_comb begin
    w_state_nxt = r_state;
    w_word_nxt  = r_word;
    w_k_nxt     = r_k;
    w_out_nxt   = r_out;
    w_last_nxt  = r_last;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_out_nxt  = '0;
        w_last_nxt = 1'b0;
        if (w_fifo_ne) begin
          w_pop       = 1'b1;
          w_state_nxt = S_EMIT;
          w_k_nxt     = '0;
          w_out_nxt   = {w_head_ext[c_EXT_W-1 -: CHUNK_W], c_MARK};
          w_last_nxt  = c_SINGLE;
          w_word_nxt  = w_head_ext << CHUNK_W;
        end
      end
      S_EMIT: begin
        if (!out_stall) begin
          if (r_k != c_K_LAST) begin
            w_k_nxt    = w_k_inc;
            w_out_nxt  = {r_word[c_EXT_W-1 -: CHUNK_W], c_MARK};
            w_last_nxt = (w_k_inc == c_K_LAST);
            w_word_nxt = r_word << CHUNK_W;
          end else if (w_fifo_ne) begin
            w_pop      = 1'b1;
            w_k_nxt    = '0;
            w_out_nxt  = {w_head_ext[c_EXT_W-1 -: CHUNK_W], c_MARK};
            w_last_nxt = c_SINGLE;
            w_word_nxt = w_head_ext << CHUNK_W;
          end else begin
            w_state_nxt = S_IDLE;
            w_out_nxt   = '0;
            w_last_nxt  = 1'b0;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_out_nxt   = '0;
        w_last_nxt  = 1'b0;
      end
    endcase
  end

  assign out      = r_out;
  assign out_last = r_last;
  assign busy     = w_fifo_ne || (r_state == S_EMIT);

endmodule

`default_nettype wire

// File: tb/tb_result_serializer.sv
// ============================================================================
// tb_result_serializer
// Scoreboard bench: directed pushes queue expected beats; per-DUT monitors
// compare every consumed beat. A second instance covers DATA_W=12.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_result_serializer;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, out_stall;
  logic [15:0] in_data;
  logic        in_ready, out_last, busy;
  logic [9:0]  out;

  logic        in_valid2, out_stall2;
  logic [11:0] in_data2;
  logic        in_ready2, out_last2, busy2;
  logic [9:0]  out2;

  int n_checks = 0;
  int n_errors = 0;

  logic [10:0] sb  [$];
  logic [10:0] sb2 [$];

  always #5 clock = ~clock;

  result_serializer #(.DATA_W(16), .CHUNK_W(8), .MARK_W(2), .DEPTH(2)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_stall(out_stall), .out(out), .out_last(out_last),
    .busy(busy)
  );

  result_serializer #(.DATA_W(12), .CHUNK_W(8), .MARK_W(2), .DEPTH(2)) dut12 (
    .clock(clock), .reset(reset), .in_valid(in_valid2), .in_data(in_data2),
    .in_ready(in_ready2), .out_stall(out_stall2), .out(out2), .out_last(out_last2),
    .busy(busy2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // A beat is consumed at the next edge when it is active and not stalled.
  always @(negedge clock) begin
    if (!reset && out != 10'd0 && !out_stall) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_errors++;
        $display("FAIL beat16: unexpected beat out=%h last=%b", out, out_last);
      end else begin
        logic [10:0] e;
        e = sb.pop_front();
        if ({out_last, out} !== e) begin
          n_errors++;
          $display("FAIL beat16: got last=%b out=%h expected last=%b out=%h",
                   out_last, out, e[10], e[9:0]);
        end
      end
    end
  end

  always @(negedge clock) begin
    if (!reset && out2 != 10'd0 && !out_stall2) begin
      n_checks++;
      if (sb2.size() == 0) begin
        n_errors++;
        $display("FAIL beat12: unexpected beat out=%h last=%b", out2, out_last2);
      end else begin
        logic [10:0] e;
        e = sb2.pop_front();
        if ({out_last2, out2} !== e) begin
          n_errors++;
          $display("FAIL beat12: got last=%b out=%h expected last=%b out=%h",
                   out_last2, out2, e[10], e[9:0]);
        end
      end
    end
  end

  // Two beats per 16-bit word: {high byte, 11} then {low byte, 11} with last.
  task automatic expect_word(input logic [15:0] w);
    sb.push_back({1'b0, w[15:8], 2'b11});
    sb.push_back({1'b1, w[7:0], 2'b11});
  endtask

  // Called just after a rising edge; the word is offered for one edge.
  task automatic push(input logic [15:0] w, input logic accept);
    in_valid = 1'b1;
    in_data  = w;
    @(negedge clock);
    check("in_ready", {31'd0, in_ready}, {31'd0, accept});
    if (accept) expect_word(w);
    @(posedge clock); #1;
    in_valid = 1'b0;
    in_data  = 16'hDEAD;
  endtask

  task automatic step();
    @(posedge clock); #1;
  endtask

  task automatic wait_idle(input int max_cycles);
    for (int i = 0; i < max_cycles && (busy || out != 10'd0); i++) step();
    check("drain_busy", {31'd0, busy}, 32'd0);
    check("drain_out", {22'd0, out}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = 16'h0; out_stall = 1'b0;
    in_valid2 = 1'b0; in_data2 = 12'h0; out_stall2 = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_out", {22'd0, out}, 32'd0);
    check("rst_last", {31'd0, out_last}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    reset = 1'b0;
    step();

    // 1: single word, latency and drain
    push(16'hA5C3, 1'b1);
    check("t1_no_bypass", {22'd0, out}, 32'd0);
    check("t1_busy", {31'd0, busy}, 32'd1);
    step();
    check("t1_c0", {21'd0, out_last, out}, {21'd0, 1'b0, 10'h297});
    step();
    check("t1_c1", {21'd0, out_last, out}, {21'd0, 1'b1, 10'h30F});
    step();
    check("t1_idle", {21'd0, out_last, out}, 32'd0);
    check("t1_busy_end", {31'd0, busy}, 32'd0);

    // 2: back-to-back words with no idle beat
    push(16'h1234, 1'b1);
    push(16'hABCD, 1'b1);
    check("t2_b0", {21'd0, out_last, out}, {21'd0, 1'b0, 10'h04B});
    step();
    check("t2_b1", {21'd0, out_last, out}, {21'd0, 1'b1, 10'h0D3});
    step();
    check("t2_b2", {21'd0, out_last, out}, {21'd0, 1'b0, 10'h2AF});
    step();
    check("t2_b3", {21'd0, out_last, out}, {21'd0, 1'b1, 10'h337});
    step();
    check("t2_idle", {22'd0, out}, 32'd0);
    wait_idle(10);

    // 3: stall fills FIFO, fourth word refused
    out_stall = 1'b1;
    push(16'h1122, 1'b1);
    push(16'h3344, 1'b1);
    push(16'h5566, 1'b1);
    push(16'h7788, 1'b0);
    check("t3_held", {21'd0, out_last, out}, {21'd0, 1'b0, 10'h047});
    check("t3_full", {31'd0, in_ready}, 32'd0);
    out_stall = 1'b0;
    wait_idle(20);
    check("t3_sb_empty", sb.size(), 32'd0);

    // 4: 3-cycle stall on chunk 0 of 0x00FF
    push(16'h00FF, 1'b1);
    step();
    check("t4_hold0", {21'd0, out_last, out}, {21'd0, 1'b0, 10'h003});
    out_stall = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      check($sformatf("t4_hold%0d", i), {21'd0, out_last, out}, {21'd0, 1'b0, 10'h003});
    end
    out_stall = 1'b0;
    step();
    check("t4_c1", {21'd0, out_last, out}, {21'd0, 1'b1, 10'h3FF});
    wait_idle(10);

    // 5: DATA_W=12 instance, 0xFED zero-extended to 0x0FED
    in_valid2 = 1'b1;
    in_data2  = 12'hFED;
    sb2.push_back({1'b0, 10'h03F});
    sb2.push_back({1'b1, 10'h3B7});
    @(negedge clock);
    check("t5_in_ready", {31'd0, in_ready2}, 32'd1);
    step();
    in_valid2 = 1'b0;
    step();
    check("t5_c0", {21'd0, out_last2, out2}, {21'd0, 1'b0, 10'h03F});
    step();
    check("t5_c1", {21'd0, out_last2, out2}, {21'd0, 1'b1, 10'h3B7});
    step();
    check("t5_idle", {22'd0, out2}, 32'd0);
    check("t5_sb_empty", sb2.size(), 32'd0);

    // 6: asynchronous reset mid-word with a second word queued
    push(16'hA5C3, 1'b1);
    push(16'h1111, 1'b1);
    @(posedge clock); #2;
    reset = 1'b1;
    #1;
    check("t6_out", {22'd0, out}, 32'd0);
    check("t6_busy", {31'd0, busy}, 32'd0);
    check("t6_in_ready", {31'd0, in_ready}, 32'd1);
    check("t6_pending", sb.size(), 32'd3);
    sb.delete();
    step();
    reset = 1'b0;
    repeat (6) step();
    check("t6_after_out", {22'd0, out}, 32'd0);
    check("t6_after_busy", {31'd0, busy}, 32'd0);

    check("final_sb_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/result_serializer.md
Name: result_serializer

Overview:
Queues wide calculation results and streams each one MSB-chunk-first onto a narrow output bus. Each active beat carries a data chunk plus an all-ones marker field; the bus reads all zeros when idle. It sits between the calculation core and the chip output pins. It adds over a fixed two-beat output stage: parametrised widths, a result FIFO with ready/valid input, a downstream stall, and a last-chunk flag.

Parameters:
DATA_W, 16, width of one result word
CHUNK_W, 8, data bits per output beat
MARK_W, 2, marker bits appended at LSBs of out; all ones on an active beat
DEPTH, 2, result FIFO entries (>=1, any integer)

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-high reset
in_valid  input  1  in_data holds a result to accept
in_data  input  DATA_W  result word
in_ready  output  1  FIFO can accept a word this cycle
out_stall  input  1  downstream not ready; hold the current active beat
out  output  CHUNK_W+MARK_W  {chunk, marker}; all zeros when idle
out_last  output  1  high with the final chunk of a word
busy  output  1  FIFO non-empty or a word is mid-emission

Behaviour:
- Reset: clock is clock; reset is reset, asynchronous, active-high.
  - On reset: out=0, out_last=0, busy=0, FIFO emptied, in_ready=1.
  - In-flight and queued words are discarded.
  - Reset takes effect immediately, not at the next edge.
- NCHUNK = ceil(DATA_W/CHUNK_W).
  - The word is zero-extended at the MSB to NCHUNK*CHUNK_W bits.
  - Chunk 0 is the most-significant CHUNK_W slice.
- Input:
  - in_ready = (FIFO count < DEPTH), registered-state based.
  - Push on in_valid && in_ready.
  - When the FIFO is full, a push is refused even if a pop occurs in the same cycle.
  - in_data is ignored when not accepted.
- Output FSM, two states; out and out_last are registered:
  - IDLE: out=0, out_last=0. At an edge, if FIFO non-empty: pop the head into the word register, drive chunk 0, k=0, go to EMIT. out_stall is ignored in IDLE.
  - EMIT: out={chunk k, MARK_W'1}, out_last=(k==NCHUNK-1).
    - At an edge with out_stall=1: hold out, out_last and k unchanged.
    - At an edge with out_stall=0 and k<NCHUNK-1: k++, drive the next chunk.
    - At an edge with out_stall=0 and k==NCHUNK-1: if FIFO non-empty, pop and drive chunk 0 of the new word (back-to-back, no gap); else go to IDLE with out=0.
- Latency: a word accepted into an empty FIFO at edge N shows chunk 0 after edge N+1. The FIFO has no bypass path.
- Push and pop in the same cycle are allowed when not full; count is unchanged.
- NCHUNK==1: every beat has out_last=1; words stream one per cycle.
- busy = (count!=0) || state==EMIT.
- Constraints: DATA_W>=CHUNK_W>=1, MARK_W>=1, DEPTH>=1.
  - Violations are caught by an elaboration-time assertion.

Test Plan:
1. Defaults, push 0xA5C3 once:
   - out=0x297, then 0x30F with out_last=1, then 0x000.
   - busy is low after the last beat.
2. Push 0x1234 and 0xABCD on consecutive cycles:
   - out=0x04B, 0x0D3(last), 0x2AF, 0x337(last) with no idle beat.
   - in_ready stays 1.
3. Hold out_stall=1 from the first chunk onward and push 4 words back-to-back:
   - Word0 is shown and held; words 1-2 fill the FIFO.
   - in_ready goes 0 and word3 is refused.
   - After stall release, three words emit in order.
4. Raise out_stall for 3 cycles while chunk 0 of 0x00FF is shown:
   - out=0x003 persists 4 cycles with marker 11.
   - Then out=0x3FF with out_last=1.
5. DATA_W=12, CHUNK_W=8, push 0xFED:
   - out=0x03F (chunk 0x0F), then 0x3B7 (chunk 0xED, last).
6. Assert reset mid-word, after the first chunk of 0xA5C3 and with one more word queued:
   - out=0 and busy=0 immediately, in_ready=1.
   - After release, no remaining chunk is emitted.
